// File: rtl/simmem_linkedlist_bank_rr_if.sv
// Handshake and status bundle for the linked-list bank: enqueue side, release side,
// per-ID release permissions and occupancy status.
interface simmem_linkedlist_bank_rr_if #(
    parameter int unsigned StructWidth   = 64,
    parameter int unsigned TotalCapacity = 16,
    parameter int unsigned IDWidth       = 2
);
    localparam int unsigned NumIds = 2 ** IDWidth;
    localparam int unsigned OccW   = $clog2(TotalCapacity) + 1;

    logic [NumIds-1:0]      release_en_i;
    logic [StructWidth-1:0] data_i;
    logic                   in_valid_i;
    logic                   in_ready_o;
    logic [StructWidth-1:0] data_o;
    logic                   out_valid_o;
    logic                   out_ready_i;
    logic [OccW-1:0]        occupancy_o;
    logic [NumIds-1:0]      id_nonempty_o;

    modport master (
        output release_en_i, data_i, in_valid_i, out_ready_i,
        input  in_ready_o, data_o, out_valid_o, occupancy_o, id_nonempty_o
    );

    modport slave (
        input  release_en_i, data_i, in_valid_i, out_ready_i,
        output in_ready_o, data_o, out_valid_o, occupancy_o, id_nonempty_o
    );
endinterface

// File: rtl/simmem_linkedlist_bank_rr.sv
// Shared-slot message bank: each ID keeps a singly linked FIFO through a common slot pool,
// and heads of permitted IDs are released through a locking round-robin arbiter.
module simmem_linkedlist_bank_rr #(
    parameter int unsigned StructWidth   = 64,
    parameter int unsigned TotalCapacity = 16,
    parameter int unsigned IDWidth       = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    simmem_linkedlist_bank_rr_if.slave    bus
);
    localparam int unsigned NumIds = 2 ** IDWidth;
    localparam int unsigned PtrW   = $clog2(TotalCapacity);
    localparam int unsigned CntW   = PtrW + 1;

    typedef logic [PtrW-1:0]    ptr_t;
    typedef logic [CntW-1:0]    cnt_t;
    typedef logic [IDWidth-1:0] id_t;

    logic [StructWidth-1:0] mem_q  [TotalCapacity];
    logic [StructWidth-1:0] mem_d  [TotalCapacity];
    ptr_t                   next_q [TotalCapacity];
    ptr_t                   next_d [TotalCapacity];
    logic [TotalCapacity-1:0] valid_q, valid_d;
    ptr_t                   head_q  [NumIds];
    ptr_t                   head_d  [NumIds];
    ptr_t                   tail_q  [NumIds];
    ptr_t                   tail_d  [NumIds];
    cnt_t                   count_q [NumIds];
    cnt_t                   count_d [NumIds];
    id_t                    rr_ptr_q, rr_ptr_d;
    id_t                    lock_id_q, lock_id_d;
    logic                   lock_q, lock_d;

    ptr_t              free_slot_s;
    logic              full_s;
    cnt_t              occupancy_s;
    logic [NumIds-1:0] cand_s;
    logic              gnt_valid_s;
    id_t               gnt_id_s;
    id_t               in_id_s;
    logic              enq_s;
    logic              deq_s;

    assign in_id_s = bus.data_i[StructWidth-1 -: IDWidth];

    // Free-slot search (lowest invalid index wins) and occupancy, from registered valid bits only.
    always_comb begin
        free_slot_s = '0;
        occupancy_s = '0;
        for (int i = TotalCapacity - 1; i >= 0; i--) begin
            free_slot_s = valid_q[i] ? free_slot_s : ptr_t'(i);
            occupancy_s = occupancy_s + cnt_t'(valid_q[i]);
        end
        full_s = &valid_q;
    end

    // Round-robin grant from rr_ptr upward; a locked grant overrides the search.
    always_comb begin
        for (int i = 0; i < NumIds; i++) begin
            cand_s[i] = (count_q[i] != '0) && bus.release_en_i[i];
        end
        gnt_valid_s = 1'b0;
        gnt_id_s    = lock_id_q;
        if (lock_q) begin
            gnt_valid_s = 1'b1;
            gnt_id_s    = lock_id_q;
        end else begin
            for (int unsigned k = 0; k < NumIds; k++) begin
                if (!gnt_valid_s && cand_s[rr_ptr_q + id_t'(k)]) begin
                    gnt_valid_s = 1'b1;
                    gnt_id_s    = rr_ptr_q + id_t'(k);
                end else begin
                    gnt_valid_s = gnt_valid_s;
                end
            end
        end
    end

    assign enq_s = bus.in_valid_i && !full_s;
    assign deq_s = gnt_valid_s && bus.out_ready_i;

    // Port drive: data_o is forced to zero whenever nothing is offered.
    always_comb begin
        bus.in_ready_o  = !full_s;
        bus.out_valid_o = gnt_valid_s;
        bus.occupancy_o = occupancy_s;
        bus.data_o      = '0;
        if (gnt_valid_s) begin
            bus.data_o = mem_q[head_q[gnt_id_s]];
        end else begin
            bus.data_o = '0;
        end
        for (int i = 0; i < NumIds; i++) begin
            bus.id_nonempty_o[i] = (count_q[i] != '0);
        end
    end

    // List update: the dequeue is applied first so a same-cycle enqueue sees the post-dequeue count.
    always_comb begin
        mem_d     = mem_q;
        next_d    = next_q;
        valid_d   = valid_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        rr_ptr_d  = rr_ptr_q;
        lock_d    = lock_q;
        lock_id_d = lock_id_q;

        if (deq_s) begin
            valid_d[head_q[gnt_id_s]] = 1'b0;
            head_d[gnt_id_s]          = next_q[head_q[gnt_id_s]];
            count_d[gnt_id_s]         = count_q[gnt_id_s] - cnt_t'(1);
            rr_ptr_d                  = gnt_id_s + id_t'(1);
            lock_d                    = 1'b0;
        end else if (gnt_valid_s) begin
            lock_d    = 1'b1;
            lock_id_d = gnt_id_s;
        end else begin
            lock_d = lock_q;
        end

        if (enq_s) begin
            mem_d[free_slot_s]   = bus.data_i;
            valid_d[free_slot_s] = 1'b1;
            if (count_d[in_id_s] == '0) begin
                head_d[in_id_s] = free_slot_s;
            end else begin
                next_d[tail_q[in_id_s]] = free_slot_s;
            end
            tail_d[in_id_s]  = free_slot_s;
            count_d[in_id_s] = count_d[in_id_s] + cnt_t'(1);
        end else begin
            valid_d = valid_d;
        end
    end

    // Control state: cleared by reset so every stored message is discarded.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q   <= '0;
            count_q   <= '{default: '0};
            rr_ptr_q  <= '0;
            lock_q    <= 1'b0;
            lock_id_q <= '0;
        end else begin
            valid_q   <= valid_d;
            count_q   <= count_d;
            rr_ptr_q  <= rr_ptr_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
        end
    end

    // Payload and pointers: only meaningful behind a valid bit or nonzero count, so no reset.
    always_ff @(posedge clk_i) begin
        mem_q  <= mem_d;
        next_q <= next_d;
        head_q <= head_d;
        tail_q <= tail_d;
    end
endmodule

// File: tb/tb_simmem_linkedlist_bank_rr.sv
// Bench for simmem_linkedlist_bank_rr: directed scenarios plus randomized traffic,
// all checked against a queue-based model of the per-ID lists and the arbiter.
module tb_simmem_linkedlist_bank_rr;
    logic clk = 1'b0;
    logic rst_ni;
    always #5 clk = ~clk;

    simmem_linkedlist_bank_rr_if #(.StructWidth(16), .TotalCapacity(8), .IDWidth(2)) bus ();

    simmem_linkedlist_bank_rr #(.StructWidth(16), .TotalCapacity(8), .IDWidth(2)) dut (
        .clk_i (clk),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // model: per-ID queues of (payload, slot), slot usage map, arbiter pointer and lock
    logic [15:0] mq_d[4][$];
    int          mq_s[4][$];
    logic [7:0]  used;
    int          rr;
    bit          lk;
    int          lk_id;

    bit          e_ready, e_valid;
    logic [15:0] e_data;
    logic [3:0]  e_occ, e_ne;
    int          e_g;

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            mq_d[i].delete();
            mq_s[i].delete();
        end
        used = 8'h00; rr = 0; lk = 1'b0; lk_id = 0;
    endtask

    function automatic int model_total();
        int t = 0;
        for (int i = 0; i < 4; i++) t += mq_d[i].size();
        return t;
    endfunction

    task automatic predict();
        e_ready = (used != 8'hFF);
        e_occ   = 4'($countones(used));
        for (int i = 0; i < 4; i++) e_ne[i] = (mq_d[i].size() > 0);
        e_valid = 1'b0;
        e_g     = 0;
        if (lk) begin
            e_valid = 1'b1;
            e_g     = lk_id;
        end else begin
            for (int k = 0; k < 4; k++) begin
                int idx = (rr + k) % 4;
                if (!e_valid && mq_d[idx].size() > 0 && bus.release_en_i[idx]) begin
                    e_valid = 1'b1;
                    e_g     = idx;
                end
            end
        end
        e_data = e_valid ? mq_d[e_g][0] : 16'h0000;
    endtask

    task automatic commit();
        int fs = 0;
        int id;
        for (int i = 7; i >= 0; i--) if (!used[i]) fs = i;
        if (e_valid && bus.out_ready_i) begin
            used[mq_s[e_g][0]] = 1'b0;
            void'(mq_d[e_g].pop_front());
            void'(mq_s[e_g].pop_front());
            rr = (e_g + 1) % 4;
            lk = 1'b0;
        end else if (e_valid) begin
            lk    = 1'b1;
            lk_id = e_g;
        end
        if (bus.in_valid_i && e_ready) begin
            id = int'(bus.data_i[15:14]);
            mq_d[id].push_back(bus.data_i);
            mq_s[id].push_back(fs);
            used[fs] = 1'b1;
        end
    endtask

    task automatic drive(bit v, logic [15:0] d, logic [3:0] rel, bit ordy);
        bus.in_valid_i   = v;
        bus.data_i       = d;
        bus.release_en_i = rel;
        bus.out_ready_i  = ordy;
    endtask

    task automatic half_neg();
        @(negedge clk);
        predict();
    endtask

    task automatic half_pos();
        @(posedge clk);
        commit();
        #1;
    endtask

    task automatic cyc();
        half_neg();
        half_pos();
    endtask

    function automatic logic [15:0] rand_msg(int id);
        logic [1:0] idb = 2'(id);
        return {idb, 14'($urandom)};
    endfunction

    task automatic apply_reset();
        drive(1'b0, 16'h0000, 4'h0, 1'b0);
        rst_ni = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        drive(1'b0, 16'h0000, 4'hF, 1'b1);
        for (int c = 0; c < 64 && model_total() > 0; c++) cyc();
        drive(1'b0, 16'h0000, 4'h0, 1'b0);
        n_cmp++;
        if (model_total() != 0) begin
            n_err++;
            $display("FAIL drain_bound: %0d messages left, required 0", model_total());
        end
    endtask

    task automatic test_reset();
        drive(1'b1, 16'hC123, 4'hF, 1'b1);
        #2;
        n_cmp += 5;
        if (bus.in_ready_o !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b expected 1", bus.in_ready_o); end
        if (bus.out_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid_o); end
        if (bus.data_o !== 16'h0000) begin n_err++; $display("FAIL rst_data: got %h expected 0000", bus.data_o); end
        if (bus.occupancy_o !== 4'd0) begin n_err++; $display("FAIL rst_occ: got %0d expected 0", bus.occupancy_o); end
        if (bus.id_nonempty_o !== 4'b0000) begin n_err++; $display("FAIL rst_nonempty: got %b expected 0000", bus.id_nonempty_o); end
        apply_reset();
    endtask

    task automatic test_fifo_order();
        logic [15:0] exp_seq[4];
        exp_seq = '{16'h0011, 16'h0022, 16'h0033, 16'h0000};
        drive(1'b1, 16'h0011, 4'h0, 1'b0); cyc();
        drive(1'b1, 16'h0022, 4'h0, 1'b0); cyc();
        drive(1'b1, 16'h0033, 4'h0, 1'b0); cyc();
        drive(1'b0, 16'h0000, 4'b0001, 1'b1);
        for (int k = 0; k < 4; k++) begin
            half_neg();
            n_cmp += 2;
            if (bus.out_valid_o !== (k < 3)) begin n_err++; $display("FAIL fifo_valid[%0d]: got %b expected %b", k, bus.out_valid_o, (k < 3)); end
            if (bus.data_o !== exp_seq[k]) begin n_err++; $display("FAIL fifo_data[%0d]: got %h expected %h", k, bus.data_o, exp_seq[k]); end
            half_pos();
        end
    endtask

    task automatic test_full();
        int freed;
        logic [15:0] nd;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, rand_msg($urandom_range(0, 3)), 4'h0, 1'b0);
            cyc();
        end
        drive(1'b0, 16'h0000, 4'h0, 1'b0);
        half_neg();
        n_cmp += 3;
        if (bus.in_ready_o !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b expected 0", bus.in_ready_o); end
        if (bus.occupancy_o !== 4'd8) begin n_err++; $display("FAIL full_occ: got %0d expected 8", bus.occupancy_o); end
        if (dut.valid_q !== 8'hFF) begin n_err++; $display("FAIL full_slots: got %h expected ff", dut.valid_q); end
        half_pos();
        drive(1'b0, 16'h0000, 4'hF, 1'b1);
        half_neg();
        freed = mq_s[e_g][0];
        half_pos();
        drive(1'b0, 16'h0000, 4'h0, 1'b0);
        half_neg();
        n_cmp += 3;
        if (bus.in_ready_o !== 1'b1) begin n_err++; $display("FAIL full_ready_after_deq: got %b expected 1", bus.in_ready_o); end
        if (bus.occupancy_o !== 4'd7) begin n_err++; $display("FAIL full_occ_after_deq: got %0d expected 7", bus.occupancy_o); end
        if (dut.valid_q !== used) begin n_err++; $display("FAIL full_slots_after_deq: got %h expected %h", dut.valid_q, used); end
        half_pos();
        nd = rand_msg($urandom_range(0, 3));
        drive(1'b1, nd, 4'h0, 1'b0);
        cyc();
        drive(1'b0, 16'h0000, 4'h0, 1'b0);
        half_neg();
        n_cmp += 2;
        if (dut.mem_q[freed] !== nd) begin n_err++; $display("FAIL refill_slot%0d: got %h expected %h", freed, dut.mem_q[freed], nd); end
        if (dut.valid_q !== 8'hFF) begin n_err++; $display("FAIL refill_slots: got %h expected ff", dut.valid_q); end
        half_pos();
        drain();
    endtask

    task automatic test_round_robin();
        logic [15:0] msgs[4];
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            msgs[k] = rand_msg(k);
            drive(1'b1, msgs[k], 4'h0, 1'b0);
            cyc();
        end
        drive(1'b0, 16'h0000, 4'hF, 1'b1);
        for (int k = 0; k < 4; k++) begin
            half_neg();
            n_cmp += 2;
            if (bus.out_valid_o !== 1'b1) begin n_err++; $display("FAIL rr_valid[%0d]: got %b expected 1", k, bus.out_valid_o); end
            if (bus.data_o !== msgs[k]) begin n_err++; $display("FAIL rr_order[%0d]: got %h expected %h", k, bus.data_o, msgs[k]); end
            half_pos();
        end
        msgs[2] = rand_msg(2);
        msgs[0] = rand_msg(0);
        drive(1'b1, msgs[2], 4'h0, 1'b0); cyc();
        drive(1'b1, msgs[0], 4'h0, 1'b0); cyc();
        drive(1'b0, 16'h0000, 4'hF, 1'b1);
        half_neg();
        n_cmp++;
        if (bus.data_o !== msgs[0]) begin n_err++; $display("FAIL rr_wrap_first: got %h expected %h", bus.data_o, msgs[0]); end
        half_pos();
        half_neg();
        n_cmp++;
        if (bus.data_o !== msgs[2]) begin n_err++; $display("FAIL rr_wrap_second: got %h expected %h", bus.data_o, msgs[2]); end
        half_pos();
        drain();
    endtask

    task automatic test_lock();
        logic [15:0] m1, m2;
        m1 = rand_msg(1);
        m2 = rand_msg(2);
        drive(1'b1, m1, 4'h0, 1'b0); cyc();
        drive(1'b1, m2, 4'h0, 1'b0); cyc();
        for (int k = 0; k < 5; k++) begin
            if (k == 0) drive(1'b0, 16'h0000, 4'b0010, 1'b0);
            else if (k < 4) drive(1'b0, 16'h0000, 4'b0100, 1'b0);
            else drive(1'b0, 16'h0000, 4'b0000, 1'b1);
            half_neg();
            n_cmp += 2;
            if (bus.out_valid_o !== 1'b1) begin n_err++; $display("FAIL lock_valid[%0d]: got %b expected 1", k, bus.out_valid_o); end
            if (bus.data_o !== m1) begin n_err++; $display("FAIL lock_data[%0d]: got %h expected %h", k, bus.data_o, m1); end
            half_pos();
        end
        drive(1'b0, 16'h0000, 4'b0000, 1'b1);
        half_neg();
        n_cmp++;
        if (bus.out_valid_o !== 1'b0) begin n_err++; $display("FAIL lock_released: got %b expected 0", bus.out_valid_o); end
        half_pos();
        drain();
    endtask

    task automatic test_same_cycle();
        drive(1'b1, 16'hC001, 4'h0, 1'b0); cyc();
        drive(1'b1, 16'hC0AA, 4'b1000, 1'b1);
        half_neg();
        n_cmp += 2;
        if (bus.data_o !== 16'hC001) begin n_err++; $display("FAIL same_first: got %h expected c001", bus.data_o); end
        if (bus.occupancy_o !== 4'd1) begin n_err++; $display("FAIL same_occ_before: got %0d expected 1", bus.occupancy_o); end
        half_pos();
        drive(1'b0, 16'h0000, 4'b1000, 1'b0);
        half_neg();
        n_cmp += 4;
        if (bus.out_valid_o !== 1'b1) begin n_err++; $display("FAIL same_valid: got %b expected 1", bus.out_valid_o); end
        if (bus.data_o !== 16'hC0AA) begin n_err++; $display("FAIL same_next: got %h expected c0aa", bus.data_o); end
        if (bus.occupancy_o !== 4'd1) begin n_err++; $display("FAIL same_occ_after: got %0d expected 1", bus.occupancy_o); end
        if (dut.count_q[3] !== 4'd1) begin n_err++; $display("FAIL same_count: got %0d expected 1", dut.count_q[3]); end
        half_pos();
        drain();
    endtask

    task automatic test_reset_mid();
        logic [15:0] nd;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, rand_msg($urandom_range(0, 3)), 4'h0, 1'b0);
            cyc();
        end
        drive(1'b0, 16'h0000, 4'hF, 1'b0);
        #2;
        rst_ni = 1'b0;
        model_clear();
        #1;
        n_cmp += 5;
        if (bus.in_ready_o !== 1'b1) begin n_err++; $display("FAIL mid_rst_ready: got %b expected 1", bus.in_ready_o); end
        if (bus.out_valid_o !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b expected 0", bus.out_valid_o); end
        if (bus.data_o !== 16'h0000) begin n_err++; $display("FAIL mid_rst_data: got %h expected 0000", bus.data_o); end
        if (bus.occupancy_o !== 4'd0) begin n_err++; $display("FAIL mid_rst_occ: got %0d expected 0", bus.occupancy_o); end
        if (bus.id_nonempty_o !== 4'b0000) begin n_err++; $display("FAIL mid_rst_nonempty: got %b expected 0000", bus.id_nonempty_o); end
        drive(1'b0, 16'h0000, 4'h0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        nd = rand_msg($urandom_range(0, 3));
        drive(1'b1, nd, 4'h0, 1'b0);
        cyc();
        drive(1'b0, 16'h0000, 4'h0, 1'b0);
        half_neg();
        n_cmp += 3;
        if (dut.valid_q !== 8'h01) begin n_err++; $display("FAIL post_rst_slots: got %h expected 01", dut.valid_q); end
        if (dut.mem_q[0] !== nd) begin n_err++; $display("FAIL post_rst_slot0: got %h expected %h", dut.mem_q[0], nd); end
        if (bus.occupancy_o !== 4'd1) begin n_err++; $display("FAIL post_rst_occ: got %0d expected 1", bus.occupancy_o); end
        half_pos();
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 2) != 0, rand_msg($urandom_range(0, 3)),
                  4'($urandom), 1'($urandom));
            half_neg();
            n_cmp += 6;
            if (bus.in_ready_o !== e_ready) begin n_err++; $display("FAIL rand_ready@%0d: got %b expected %b", c, bus.in_ready_o, e_ready); end
            if (bus.out_valid_o !== e_valid) begin n_err++; $display("FAIL rand_valid@%0d: got %b expected %b", c, bus.out_valid_o, e_valid); end
            if (bus.data_o !== e_data) begin n_err++; $display("FAIL rand_data@%0d: got %h expected %h", c, bus.data_o, e_data); end
            if (bus.occupancy_o !== e_occ) begin n_err++; $display("FAIL rand_occ@%0d: got %0d expected %0d", c, bus.occupancy_o, e_occ); end
            if (bus.id_nonempty_o !== e_ne) begin n_err++; $display("FAIL rand_nonempty@%0d: got %b expected %b", c, bus.id_nonempty_o, e_ne); end
            if (dut.valid_q !== used) begin n_err++; $display("FAIL rand_slots@%0d: got %h expected %h", c, dut.valid_q, used); end
            half_pos();
        end
        drain();
    endtask

    initial begin
        rst_ni = 1'b0;
        model_clear();
        test_reset();
        test_fifo_order();
        test_full();
        test_round_robin();
        test_lock();
        test_same_cycle();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end
endmodule
